phy_tx_lanes: RTL and testbench

Single-clock transmit-side PHY that stripes a 32-bit word stream across two serial lanes, matching the two-lane receive PHY. Accepts one word every 16 `clk_32f` cycles, sends even slots on lane 0 and odd slots on lane 1, and serializes each word MSB-first. Lane idle time is filled with the 0xBC alignment byte so the receiver's lane activity detection can lock. All clock-rate division is done with enable strobes from one free-running counter; no derived clocks.

---
 rtl/phy_pkg.sv | 20 ++
 rtl/par_serial_lane.sv | 33 +++
 rtl/phy_tx_lanes.sv | 86 ++++++++
 tb/tb_phy_tx_lanes.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared constants for the two-lane transmit PHY.
package phy_pkg;

   localparam int FRAME_W     = 32;
   localparam int CNT_W       = 5;
   localparam int INIT_FRAMES = 1;

   localparam logic [7:0]         IDLE_BYTE  = 8'hBC;
   localparam logic [FRAME_W-1:0] IDLE_FRAME = {4{IDLE_BYTE}};
   localparam logic [CNT_W-1:0]   SLOT_A     = 5'd15;
   localparam logic [CNT_W-1:0]   SLOT_B     = 5'd31;

   function automatic logic [FRAME_W-1:0] frame_or_idle(
      input logic               vld,
      input logic [FRAME_W-1:0] word
   );
      return vld ? word : IDLE_FRAME;
   endfunction

endpackage

// File: rtl/par_serial_lane.sv
// One serial lane: frame register with idle substitution and MSB-first output flop.
module par_serial_lane
   import phy_pkg::*;
(
   input  logic               clk_32f,
   input  logic               reset,
   input  logic               load,
   input  logic               valid,
   input  logic [FRAME_W-1:0] word,
   input  logic [CNT_W-1:0]   sel,
   output logic               data_out
);

   logic [FRAME_W-1:0] frame;
   logic [FRAME_W-1:0] frame_nxt;

   always_comb begin
      frame_nxt = frame;
      if (load) frame_nxt = frame_or_idle(valid, word);
   end

   // sel is next cycle's count, so the flop presents bit 31-cnt in that cycle
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         frame    <= IDLE_FRAME;
         data_out <= 1'b0;
      end else begin
         frame    <= frame_nxt;
         data_out <= frame_nxt[~sel];
      end
   end

endmodule

// File: rtl/phy_tx_lanes.sv
// Two-lane transmit PHY: frame counter, init frames, slot decode, lane-0 hold.
module phy_tx_lanes
   import phy_pkg::*;
(
   input  logic               clk_32f,
   input  logic               reset,
   input  logic [FRAME_W-1:0] data_in,
   input  logic               valid_in,
   output logic               ready_out,
   output logic               data_out0,
   output logic               data_out1,
   output logic               active_out
);

   localparam int INIT_W = $clog2(INIT_FRAMES + 1);

   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               run;
   logic [INIT_W-1:0]  init_cnt;
   logic [FRAME_W-1:0] hold;
   logic               hold_vld;
   logic               slot_a;
   logic               slot_b;
   logic               acc;

   assign slot_a    = run && (cnt == SLOT_A);
   assign slot_b    = run && (cnt == SLOT_B);
   assign ready_out = active_out && (slot_a || slot_b);
   assign acc       = valid_in && ready_out;

   // The counter holds 0 for the first post-reset edge so the output
   // flops can pre-load bit 31 for the cnt==0 cycle.
   assign cnt_nxt = run ? cnt + 1'b1 : '0;

   always_ff @(posedge clk_32f) begin
      if (reset) begin
         run <= 1'b0;
         cnt <= '0;
      end else begin
         run <= 1'b1;
         cnt <= cnt_nxt;
      end
   end

   always_ff @(posedge clk_32f) begin
      if (reset) begin
         init_cnt   <= '0;
         active_out <= 1'b0;
      end else if (slot_b && !active_out) begin
         if (init_cnt == INIT_W'(INIT_FRAMES - 1)) active_out <= 1'b1;
         else init_cnt <= init_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_32f) begin
      if (reset) begin
         hold     <= IDLE_FRAME;
         hold_vld <= 1'b0;
      end else if (slot_a) begin
         hold     <= frame_or_idle(acc, data_in);
         hold_vld <= acc;
      end
   end

   par_serial_lane u_lane0 (
      .clk_32f  (clk_32f),
      .reset    (reset),
      .load     (slot_b),
      .valid    (hold_vld),
      .word     (hold),
      .sel      (cnt_nxt),
      .data_out (data_out0)
   );

   par_serial_lane u_lane1 (
      .clk_32f  (clk_32f),
      .reset    (reset),
      .load     (slot_b),
      .valid    (acc),
      .word     (data_in),
      .sel      (cnt_nxt),
      .data_out (data_out1)
   );

endmodule

// File: tb/tb_phy_tx_lanes.sv
// Directed bench for phy_tx_lanes: whole-frame captures checked by assertion.
module tb_phy_tx_lanes;

   logic        clk_32f = 1'b0;
   logic        reset;
   logic [31:0] data_in;
   logic        valid_in;
   logic        ready_out;
   logic        data_out0;
   logic        data_out1;
   logic        active_out;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [31:0] IDLE = 32'hBCBCBCBC;
   localparam logic [31:0] RDY  = 32'h8000_8000;

   always #5 clk_32f = ~clk_32f;

   phy_tx_lanes dut (
      .clk_32f    (clk_32f),
      .reset      (reset),
      .data_in    (data_in),
      .valid_in   (valid_in),
      .ready_out  (ready_out),
      .data_out0  (data_out0),
      .data_out1  (data_out1),
      .active_out (active_out)
   );

   task automatic tick();
      @(posedge clk_32f);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Runs one 32-cycle frame starting at cnt==0; bit k of rdy/act is cnt==k
   task automatic frame(input logic va, input logic [31:0] da,
                        input logic vb, input logic [31:0] db,
                        input logic junk,
                        output logic [31:0] l0, output logic [31:0] l1,
                        output logic [31:0] rdy, output logic [31:0] act);
      for (int k = 0; k < 32; k++) begin
         l0[31-k] = data_out0;
         l1[31-k] = data_out1;
         rdy[k]   = ready_out;
         act[k]   = active_out;
         valid_in = 1'b0;
         data_in  = 32'h0;
         if (k == 15) begin
            valid_in = va;
            data_in  = da;
         end else if (k == 31) begin
            valid_in = vb;
            data_in  = db;
         end else if (junk && (k == 14 || k == 16)) begin
            valid_in = 1'b1;
            data_in  = 32'hFFFFFFFF;
         end
         tick();
      end
   endtask

   logic [31:0] l0, l1, rdy, act;
   logic [19:0] part;
   logic [31:0] wa, wb, pa, pb;

   initial begin
      reset    = 1'b1;
      valid_in = 1'b0;
      data_in  = 32'h0;
      tick();
      tick();
      chk("rst_out0", {31'b0, data_out0}, 32'd0);
      chk("rst_out1", {31'b0, data_out1}, 32'd0);
      chk("rst_ready", {31'b0, ready_out}, 32'd0);
      chk("rst_active", {31'b0, active_out}, 32'd0);
      reset = 1'b0;
      tick();

      frame(0, 0, 0, 0, 0, l0, l1, rdy, act);
      chk("init_l0", l0, IDLE);
      chk("init_l1", l1, IDLE);
      chk("init_rdy", rdy, 32'h0);
      chk("init_act", act, 32'h0);

      frame(1, 32'hDEADBEEF, 0, 0, 0, l0, l1, rdy, act);
      chk("f1_l0", l0, IDLE);
      chk("f1_l1", l1, IDLE);
      chk("f1_rdy", rdy, RDY);
      chk("f1_act", act, 32'hFFFFFFFF);

      frame(1, 32'h01234567, 1, 32'h89ABCDEF, 0, l0, l1, rdy, act);
      chk("deadbeef_l0", l0, 32'hDEADBEEF);
      chk("deadbeef_l1", l1, IDLE);

      frame(0, 0, 0, 0, 1, l0, l1, rdy, act);
      chk("pair_l0", l0, 32'h01234567);
      chk("pair_l1", l1, 32'h89ABCDEF);

      frame(0, 0, 0, 0, 0, l0, l1, rdy, act);
      chk("junk_l0", l0, IDLE);
      chk("junk_l1", l1, IDLE);

      frame(1, 32'hA5A5A5A5, 0, 0, 0, l0, l1, rdy, act);
      chk("pre_a5_l0", l0, IDLE);

      for (int k = 0; k < 20; k++) begin
         part[19-k] = data_out0;
         valid_in   = (k == 15);
         data_in    = (k == 15) ? 32'h12345678 : 32'h0;
         tick();
      end
      valid_in = 1'b0;
      data_in  = 32'h0;
      chk("a5_partial", {12'h0, part}, {12'h0, 20'hA5A5A});
      reset = 1'b1;
      tick();
      chk("midrst_out0", {31'b0, data_out0}, 32'd0);
      chk("midrst_out1", {31'b0, data_out1}, 32'd0);
      chk("midrst_act", {31'b0, active_out}, 32'd0);
      tick();
      reset = 1'b0;
      tick();

      frame(1, 32'hCAFEF00D, 1, 32'hCAFEF00D, 0, l0, l1, rdy, act);
      chk("reinit_l0", l0, IDLE);
      chk("reinit_l1", l1, IDLE);
      chk("reinit_rdy", rdy, 32'h0);
      chk("reinit_act", act, 32'h0);

      pa = IDLE;
      pb = IDLE;
      for (int i = 0; i < 8; i++) begin
         wa = $urandom;
         wb = $urandom;
         frame(1, wa, 1, wb, 0, l0, l1, rdy, act);
         chk("rnd_l0", l0, pa);
         chk("rnd_l1", l1, pb);
         chk("rnd_rdy", rdy, RDY);
         pa = wa;
         pb = wb;
      end
      frame(0, 0, 1, 32'h0F0F0F0F, 0, l0, l1, rdy, act);
      chk("last_l0", l0, pa);
      chk("last_l1", l1, pb);
      frame(0, 0, 0, 0, 0, l0, l1, rdy, act);
      chk("bonly_l0", l0, IDLE);
      chk("bonly_l1", l1, 32'h0F0F0F0F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
